// File: rtl/jpeg_rle_pkg.sv
// Shared types and helpers for the JPEG AC run-length path.
// The size helper is also used by the DC DPCM path.
package jpeg_rle_pkg;

    localparam int DEF_COEF_W = 16;
    localparam int DEF_AMP_W  = 11;
    localparam int DEF_SIZE_W = 4;

    localparam int         BLK_LEN  = 64;
    localparam logic [5:0] LAST_IDX = 6'd63;

    localparam logic [3:0] ZRL_RUN = 4'd15;
    localparam logic [3:0] EOB_RUN = 4'd0;

    typedef struct packed {
        logic [3:0]            run;
        logic [DEF_SIZE_W-1:0] size;
        logic [DEF_AMP_W-1:0]  amp;
        logic                  eob;
    } ac_sym_t;

    // Unsaturated bit length of |coef|; callers clamp to their amplitude width.
    function automatic int size_of(input logic [DEF_COEF_W-1:0] coef);
        logic [DEF_COEF_W:0] mag;
        int                  len;
        mag = coef[DEF_COEF_W-1] ? -{1'b1, coef} : {1'b0, coef};
        len = 0;
        for (int i = 0; i <= DEF_COEF_W; i++) begin
            if (mag[i]) len = i + 1;
        end
        return len;
    endfunction

endpackage

// File: rtl/ac_rle_encoder_amp_size.sv
// Combinational coefficient -> {size category, amplitude bits}.
// Negative values use the ones'-complement form (c-1) truncated to size bits.
module ac_amp_size
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = DEF_COEF_W,
    parameter int AMP_W  = DEF_AMP_W,
    parameter int SIZE_W = DEF_SIZE_W
) (
    input  logic [COEF_W-1:0] coef,
    output logic [SIZE_W-1:0] size,
    output logic [AMP_W-1:0]  amp,
    output logic              ovf
);

    int               len;
    int               sz;
    logic [AMP_W-1:0] adj;

    always_comb begin
        len  = size_of(coef);
        ovf  = (len > AMP_W);
        sz   = ovf ? AMP_W : len;
        size = sz[SIZE_W-1:0];
        // Only the low AMP_W bits of (c-1) can survive the size mask.
        adj  = coef[AMP_W-1:0] - {{(AMP_W-1){1'b0}}, coef[COEF_W-1]};
        for (int i = 0; i < AMP_W; i++) begin
            amp[i] = (i < sz) ? adj[i] : 1'b0;
        end
    end

endmodule

// File: rtl/ac_rle_encoder.sv
// JPEG AC run/size/amplitude symbol generator for one zig-zag 8x8 block.
//   state  | meaning
//   S_IDLE | waiting for blk_start_i; coefficient 0 (DC) is never encoded
//   S_RUN  | consuming AC indices 1..63, one per cycle
module ac_rle_encoder
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = DEF_COEF_W,
    parameter int AMP_W  = DEF_AMP_W,
    parameter int SIZE_W = DEF_SIZE_W
) (
    input  logic              clk_x8_i,
    input  logic              rst_n_i,
    input  logic              blk_start_i,
    input  logic [5:0]        last_idx_i,
    input  logic [COEF_W-1:0] coef_i,
    output logic              sym_valid_o,
    output logic [3:0]        sym_run_o,
    output logic [SIZE_W-1:0] sym_size_o,
    output logic [AMP_W-1:0]  sym_amp_o,
    output logic              sym_eob_o,
    output logic              blk_done_o,
    output logic              busy_o
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t      state;
    logic [5:0]  idx;
    logic [5:0]  last;
    logic [3:0]  run;

    logic [SIZE_W-1:0] c_size;
    logic [AMP_W-1:0]  c_amp;
    logic              c_ovf;
    logic              coef_nz;
    logic              in_blk;
    logic              at_eob;
    logic              at_end;
    logic              abort;

    ac_amp_size #(
        .COEF_W (COEF_W),
        .AMP_W  (AMP_W),
        .SIZE_W (SIZE_W)
    ) u_amp_size (
        .coef (coef_i),
        .size (c_size),
        .amp  (c_amp),
        .ovf  (c_ovf)
    );

    always_comb begin
        coef_nz = |coef_i;
        in_blk  = (idx <= last);
        // With last==63 the sum is 64, which idx never reaches: no EOB.
        at_eob  = ({1'b0, idx} == ({1'b0, last} + 7'd1));
        at_end  = (idx == LAST_IDX);
        abort   = blk_start_i && !at_end;
    end

    always_ff @(posedge clk_x8_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            idx         <= '0;
            last        <= '0;
            run         <= '0;
            sym_valid_o <= 1'b0;
            sym_run_o   <= '0;
            sym_size_o  <= '0;
            sym_amp_o   <= '0;
            sym_eob_o   <= 1'b0;
            blk_done_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            sym_valid_o <= 1'b0;
            sym_run_o   <= '0;
            sym_size_o  <= '0;
            sym_amp_o   <= '0;
            sym_eob_o   <= 1'b0;
            blk_done_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (blk_start_i) begin
                        last   <= last_idx_i;
                        idx    <= 6'd1;
                        run    <= '0;
                        state  <= S_RUN;
                        busy_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        last <= last_idx_i;
                        idx  <= 6'd1;
                        run  <= '0;
                    end else begin
                        if (in_blk) begin
                            if (coef_nz) begin
                                sym_valid_o <= 1'b1;
                                sym_run_o   <= run;
                                sym_size_o  <= c_size;
                                sym_amp_o   <= c_amp;
                                run         <= '0;
                            end else if (run == ZRL_RUN) begin
                                sym_valid_o <= 1'b1;
                                sym_run_o   <= ZRL_RUN;
                                run         <= '0;
                            end else begin
                                run <= run + 4'd1;
                            end
                        end else if (at_eob) begin
                            sym_valid_o <= 1'b1;
                            sym_run_o   <= EOB_RUN;
                            sym_eob_o   <= 1'b1;
                        end
                        if (at_end) begin
                            blk_done_o <= 1'b1;
                            if (blk_start_i) begin
                                last <= last_idx_i;
                                idx  <= 6'd1;
                                run  <= '0;
                            end else begin
                                idx    <= '0;
                                state  <= S_IDLE;
                                busy_o <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 6'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Magnitudes wider than AMP_W bits are illegal input; size saturates.
    assert property (@(posedge clk_x8_i) disable iff (!rst_n_i)
        !((state == S_RUN) && !abort && in_blk && coef_nz && c_ovf));

endmodule

// File: tb/tb_ac_rle_encoder.sv
// Directed bench for ac_rle_encoder with a cycle-stamped symbol scoreboard.
module tb_ac_rle_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        blk_start;
    logic [5:0]  last_idx;
    logic [15:0] coef;
    logic        sym_valid;
    logic [3:0]  sym_run;
    logic [3:0]  sym_size;
    logic [10:0] sym_amp;
    logic        sym_eob;
    logic        blk_done;
    logic        busy;

    ac_rle_encoder dut (
        .clk_x8_i    (clk),
        .rst_n_i     (rst_n),
        .blk_start_i (blk_start),
        .last_idx_i  (last_idx),
        .coef_i      (coef),
        .sym_valid_o (sym_valid),
        .sym_run_o   (sym_run),
        .sym_size_o  (sym_size),
        .sym_amp_o   (sym_amp),
        .sym_eob_o   (sym_eob),
        .blk_done_o  (blk_done),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int cyc;
        int run;
        int size;
        int amp;
        int eob;
    } exp_t;

    exp_t sq[$];
    int   dq[$];
    int   blk[2][64];
    int   lastv[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bitlen(input int v);
        int a;
        int n;
        a = (v < 0) ? -v : v;
        n = 0;
        while (a != 0) begin
            n++;
            a = a >> 1;
        end
        return n;
    endfunction

    function automatic void push_sym(input int c, input int r, input int s, input int a, input int e);
        exp_t x;
        x.cyc  = c;
        x.run  = r;
        x.size = s;
        x.amp  = a;
        x.eob  = e;
        sq.push_back(x);
    endfunction

    // JPEG AC coding of block s; cut < 64 means the block is aborted at index cut.
    function automatic void expect_block(input int s, input int base, input int cut);
        int run;
        int n;
        int v;
        run = 0;
        for (int k = 1; k < cut; k++) begin
            v = blk[s][k];
            if (k <= lastv[s]) begin
                if (v != 0) begin
                    n = bitlen(v);
                    push_sym(base + 1 + k, run, n, (v > 0) ? v : v + (1 << n) - 1, 0);
                    run = 0;
                end else if (run == 15) begin
                    push_sym(base + 1 + k, 15, 0, 0, 0);
                    run = 0;
                end else begin
                    run++;
                end
            end else if (k == lastv[s] + 1) begin
                push_sym(base + 1 + k, 0, 0, 0, 1);
            end
        end
        if (cut == 64) dq.push_back(base + 64);
    endfunction

    exp_t        me;
    int          md;
    logic [31:0] mc;

    always @(negedge clk) begin
        if (rst_n) begin
            mc = 32'(cyc);
            if (sym_valid) begin
                if (sq.size() == 0) begin
                    check("sym_unexpected", {63'd0, sym_valid}, 64'd0);
                end else begin
                    me = sq.pop_front();
                    check("sym", {12'd0, mc, sym_run, sym_size, sym_amp, sym_eob},
                          {12'd0, 32'(me.cyc), 4'(me.run), 4'(me.size), 11'(me.amp), 1'(me.eob)});
                end
            end
            if (blk_done) begin
                if (dq.size() == 0) begin
                    check("done_unexpected", {63'd0, blk_done}, 64'd0);
                end else begin
                    md = dq.pop_front();
                    check("done", {32'd0, mc}, {32'd0, 32'(md)});
                end
            end
        end
    end

    task automatic drive(input logic st, input int li, input int c);
        blk_start = st;
        last_idx  = 6'(li);
        coef      = 16'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            drive(k == 0, (k == 0) ? lastv[s] : int'($urandom_range(0, 63)), blk[s][k]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0);
    endtask

    function automatic int rnz();
        int v;
        v = int'($urandom_range(1, 2047));
        return ($urandom_range(0, 1) == 1) ? -v : v;
    endfunction

    task automatic clear(input int s, input int last);
        lastv[s] = last;
        for (int k = 0; k < 64; k++) blk[s][k] = 0;
        blk[s][0] = rnz();
    endtask

    // Random contents; indices past last carry garbage the DUT must ignore.
    task automatic gen(input int s, input int last);
        lastv[s] = last;
        for (int k = 0; k < 64; k++) begin
            blk[s][k] = (k == 0 || k > last || $urandom_range(0, 2) == 0) ? rnz() : 0;
        end
        if (last > 0) blk[s][last] = rnz();
    endtask

    task automatic run_block(input int s);
        int base;
        base = cyc;
        expect_block(s, base, 64);
        send(s, 0, 64);
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        blk_start = 1'b0;
        last_idx  = '0;
        coef      = '0;
        #3;
        check("rst_valid", {63'd0, sym_valid}, 64'd0);
        check("rst_run",   {60'd0, sym_run},   64'd0);
        check("rst_size",  {60'd0, sym_size},  64'd0);
        check("rst_amp",   {53'd0, sym_amp},   64'd0);
        check("rst_eob",   {63'd0, sym_eob},   64'd0);
        check("rst_done",  {63'd0, blk_done},  64'd0);
        check("rst_busy",  {63'd0, busy},      64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // single coefficient 5 at k=1
        clear(0, 1);
        blk[0][1] = 5;
        run_block(0);
        check("busy_after_blk", {63'd0, busy}, 64'd0);
        idle(2);

        // all-zero AC, EOB at k=1; busy checked right after start
        clear(0, 0);
        base = cyc;
        expect_block(0, base, 64);
        drive(1'b1, 0, blk[0][0]);
        check("busy_in_run", {63'd0, busy}, 64'd1);
        send(0, 1, 64);
        idle(2);

        // -3 at k=20: ZRL then (3,2,0) then EOB
        clear(0, 20);
        blk[0][20] = -3;
        run_block(0);
        idle(2);

        // last==63: three ZRLs, no EOB
        clear(0, 63);
        blk[0][1]  = -1;
        blk[0][63] = 1;
        run_block(0);
        idle(2);

        // amplitude extremes
        clear(0, 5);
        blk[0][1] = 2047;
        blk[0][2] = -2047;
        blk[0][3] = -1024;
        blk[0][4] = 1024;
        blk[0][5] = 1;
        run_block(0);
        idle(1);

        // abort at k=10 by a new start
        gen(0, 40);
        base = cyc;
        expect_block(0, base, 10);
        send(0, 0, 10);
        gen(1, 25);
        run_block(1);
        idle(2);

        // back-to-back: block 2 starts on block 1's k=63 cycle
        gen(0, 50);
        gen(1, 63);
        base = cyc;
        expect_block(0, base, 64);
        send(0, 0, 63);
        base = cyc;
        drive(1'b1, lastv[1], blk[0][63]);
        expect_block(1, base, 64);
        send(1, 1, 64);
        idle(2);

        // asynchronous reset at k=30
        clear(0, 45);
        blk[0][5]  = 7;
        blk[0][29] = -2;
        blk[0][40] = 100;
        base = cyc;
        expect_block(0, base, 64);
        send(0, 0, 30);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {63'd0, sym_valid}, 64'd0);
        check("arst_run",   {60'd0, sym_run},   64'd0);
        check("arst_size",  {60'd0, sym_size},  64'd0);
        check("arst_amp",   {53'd0, sym_amp},   64'd0);
        check("arst_busy",  {63'd0, busy},      64'd0);
        sq.delete();
        dq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        gen(0, 33);
        run_block(0);
        idle(4);

        check("sym_queue_empty",  64'(sq.size()), 64'd0);
        check("done_queue_empty", 64'(dq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
